// File: rtl/axis_stream_joiner_if.sv
// AXI-Stream bundle used on both sides of axis_stream_joiner.
// LANES sets the width of the handshake/last vectors (one bit per lane);
// DATA_W and USER_W are the total widths of the tdata and tuser buses.
interface axis_stream_joiner_if #(
  parameter int LANES  = 1,
  parameter int DATA_W = 64,
  parameter int USER_W = 8
);
  logic [LANES-1:0]  tvalid;
  logic [LANES-1:0]  tready;
  logic [LANES-1:0]  tlast;
  logic [DATA_W-1:0] tdata;
  logic [USER_W-1:0] tuser;

  modport master (output tvalid, output tlast, output tdata, output tuser, input  tready);
  modport slave  (input  tvalid, input  tlast, input  tdata, input  tuser, output tready);
endinterface

// File: rtl/axis_stream_joiner.sv
// axis_stream_joiner: joins N_STREAMS AXI-Stream lanes into one lockstep beat.
// Each lane is buffered in a small FIFO to absorb producer skew. A tlast
// disagreement between checked lanes raises the sticky err_last flag and,
// when FLUSH_ON_ERR is set, drains every lane to its frame boundary before
// joining resumes. beat_count counts output handshakes.
// Optional macro AXIS_JOINER_STALL_CNT_EN adds stall_cycles/bp_cycles counters.
module axis_stream_joiner #(
  parameter int                              N_STREAMS       = 2,
  parameter int                              DATA_WIDTH      = 64,
  parameter int                              USER_WIDTH      = 8,
  parameter int                              DEPTH           = 4,
  parameter int                              LAST_SRC        = 0,
  parameter logic [N_STREAMS-1:0]            LAST_CHECK_MASK = '1,
  parameter logic [N_STREAMS*USER_WIDTH-1:0] USER_GATE_MASK  = '0,
  parameter int                              FLUSH_ON_ERR    = 1,
  parameter int                              CNT_WIDTH       = 32
) (
  input  logic                  aclk,
  input  logic                  areset,
  axis_stream_joiner_if.slave   s_axis,
  axis_stream_joiner_if.master  m_axis,
  output logic                  err_last,
  input  logic                  err_clear,
  output logic [CNT_WIDTH-1:0]  beat_count
`ifdef AXIS_JOINER_STALL_CNT_EN
  ,
  output logic [CNT_WIDTH-1:0]  stall_cycles,
  output logic [CNT_WIDTH-1:0]  bp_cycles
`endif
);

  localparam int PW = $clog2(DEPTH);
  localparam int EW = 1 + USER_WIDTH + DATA_WIDTH;
  localparam logic [PW:0] FULL_CNT = (PW+1)'(DEPTH);

  typedef enum logic {S_RUN, S_DRAIN} state_t;

  logic [EW-1:0]   mem_q    [N_STREAMS][DEPTH];
  logic [PW-1:0]   wr_ptr_q [N_STREAMS];
  logic [PW-1:0]   rd_ptr_q [N_STREAMS];
  logic [PW:0]     cnt_q    [N_STREAMS];
  logic            rdy_en_q;
  state_t          state_q, state_d;
  logic [N_STREAMS-1:0] done_q, done_d;
  logic            err_q, err_d;
  logic [CNT_WIDTH-1:0] beat_q;

  logic [N_STREAMS-1:0]            empty, full, push, pop, head_last;
  logic [N_STREAMS*DATA_WIDTH-1:0] head_data;
  logic [N_STREAMS*USER_WIDTH-1:0] head_user;
  logic [N_STREAMS-1:0]            last_chk;
  logic m_valid, fire, mismatch;

  // Per-lane FIFO status and head-of-queue fields.
  always_comb begin
    for (int i = 0; i < N_STREAMS; i++) begin
      empty[i]     = (cnt_q[i] == '0);
      full[i]      = (cnt_q[i] == FULL_CNT);
      head_last[i] = mem_q[i][rd_ptr_q[i]][EW-1];
      head_user[i*USER_WIDTH +: USER_WIDTH] = mem_q[i][rd_ptr_q[i]][DATA_WIDTH +: USER_WIDTH];
      head_data[i*DATA_WIDTH +: DATA_WIDTH] = mem_q[i][rd_ptr_q[i]][DATA_WIDTH-1:0];
    end
  end

  // Ready is purely registered: held low through reset, then !full.
  assign s_axis.tready = {N_STREAMS{rdy_en_q}} & ~full;
  assign push          = s_axis.tvalid & s_axis.tready;

  assign m_valid  = (state_q == S_RUN) && !(|empty);
  assign fire     = m_valid && m_axis.tready[0];
  // Checked lanes disagree when some, but not all, of them carry tlast.
  assign last_chk = head_last & LAST_CHECK_MASK;
  assign mismatch = (last_chk != '0) && (last_chk != LAST_CHECK_MASK);

  assign m_axis.tvalid = m_valid;
  assign m_axis.tlast  = head_last[LAST_SRC];
  assign m_axis.tdata  = head_data;
  assign m_axis.tuser  = head_user & (~USER_GATE_MASK | {(N_STREAMS*USER_WIDTH){m_valid}});
  assign err_last      = err_q;
  assign beat_count    = beat_q;

  // Next state, pops, drain bookkeeping and the sticky error flag.
  always_comb begin
    state_d = state_q;
    done_d  = done_q;
    pop     = '0;
    err_d   = err_q;
    if (err_clear) err_d = 1'b0;
    case (state_q)
      S_RUN: begin
        if (fire) begin
          pop = '1;
          if (mismatch) begin
            err_d = 1'b1;
            if (FLUSH_ON_ERR != 0) begin
              state_d = S_DRAIN;
              // Lanes already at their boundary, or unchecked, wait for the rest.
              done_d  = head_last | ~LAST_CHECK_MASK;
            end
          end
        end
      end
      S_DRAIN: begin
        pop    = ~done_q & ~empty;
        done_d = done_q | (pop & head_last);
        if (&done_d) begin
          state_d = S_RUN;
          done_d  = '0;
        end
      end
      default: state_d = S_RUN;
    endcase
  end

  // FSM, error flag, ready enable and beat counter registers.
  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      state_q  <= S_RUN;
      done_q   <= '0;
      err_q    <= 1'b0;
      rdy_en_q <= 1'b0;
      beat_q   <= '0;
    end else begin
      state_q  <= state_d;
      done_q   <= done_d;
      err_q    <= err_d;
      rdy_en_q <= 1'b1;
      beat_q   <= beat_q + CNT_WIDTH'(fire);
    end
  end

  // FIFO occupancy and pointers; pointers wrap since DEPTH is a power of two.
  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      for (int i = 0; i < N_STREAMS; i++) begin
        cnt_q[i]    <= '0;
        wr_ptr_q[i] <= '0;
        rd_ptr_q[i] <= '0;
      end
    end else begin
      for (int i = 0; i < N_STREAMS; i++) begin
        cnt_q[i] <= cnt_q[i] + (PW+1)'(push[i]) - (PW+1)'(pop[i]);
        if (push[i]) wr_ptr_q[i] <= wr_ptr_q[i] + PW'(1);
        if (pop[i])  rd_ptr_q[i] <= rd_ptr_q[i] + PW'(1);
      end
    end
  end

  // FIFO storage: data only, no reset needed since occupancy guards reads.
  always_ff @(posedge aclk) begin
    for (int i = 0; i < N_STREAMS; i++) begin
      if (push[i]) begin
        mem_q[i][wr_ptr_q[i]] <= {s_axis.tlast[i],
                                  s_axis.tuser[i*USER_WIDTH +: USER_WIDTH],
                                  s_axis.tdata[i*DATA_WIDTH +: DATA_WIDTH]};
      end
    end
  end

`ifdef AXIS_JOINER_STALL_CNT_EN
  logic [CNT_WIDTH-1:0] stall_q, bp_q;
  assign stall_cycles = stall_q;
  assign bp_cycles    = bp_q;

  // Skew stalls (data waiting on a lagging lane) and downstream backpressure.
  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      stall_q <= '0;
      bp_q    <= '0;
    end else begin
      if ((state_q == S_RUN) && !m_valid && !(&empty)) stall_q <= stall_q + CNT_WIDTH'(1);
      if (m_valid && !m_axis.tready[0])                bp_q    <= bp_q + CNT_WIDTH'(1);
    end
  end
`endif

endmodule
